// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding RV32 LW/SW sequencer between register read and data memory.
// Define LSU_CTRL_TIMEOUT_EN to add a watchdog on the response wait (error code 11).
module lsu_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [31:0]     req_instr,
  input  logic [XLEN-1:0] req_rs1_val,
  input  logic [XLEN-1:0] req_rs2_val,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            cmpl_valid,
  output logic [1:0]      cmpl_err,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_MISALGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  logic [1:0]      err_q, err_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            is_load, is_store, illegal;
  logic [11:0]     imm;
  logic [XLEN-1:0] eff_addr;
  logic            timed_out;
  logic            unused_instr;

  assign opcode   = req_instr[6:0];
  assign funct3   = req_instr[14:12];
  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  assign illegal  = !(is_load || is_store) || (funct3 != 3'b010);
  assign imm      = is_store ? {req_instr[31:25], req_instr[11:7]} : req_instr[31:20];
  assign eff_addr = req_rs1_val + {{(XLEN-12){imm[11]}}, imm};
  // rs1 field index is resolved upstream; only its value arrives here
  assign unused_instr = ^req_instr[19:15];

`ifdef LSU_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign timed_out = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_ISSUE) begin
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT > 0);
  assign timed_out  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rd_d      = rd_q;
    err_d     = err_q;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (illegal) begin
            err_d   = ERR_ILLEGAL;
            state_d = S_RESP;
          end else if (eff_addr[1:0] != 2'b00) begin
            err_d   = ERR_MISALGN;
            state_d = S_RESP;
          end else begin
            err_d   = ERR_OK;
            addr_d  = eff_addr;
            wdata_d = req_rs2_val;
            we_d    = is_store;
            rd_d    = req_instr[11:7];
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        // a response in the final counted cycle beats the watchdog
        if (mem_rsp_valid) begin
          state_d = S_RESP;
          if (!we_q && rd_q != 5'd0) begin
            wb_rd_d   = rd_q;
            wb_data_d = mem_rdata;
          end
        end else if (timed_out) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      err_q     <= ERR_OK;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign req_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign mem_req_valid = (state_q == S_ISSUE);
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_we        = we_q;
  assign mem_be        = 4'hF;
  assign cmpl_valid    = (state_q == S_RESP);
  assign cmpl_err      = (state_q == S_RESP) ? err_q : ERR_OK;
  // err_q gates out the stale we_q/rd_q left behind by an error-path instruction
  assign wb_valid      = (state_q == S_RESP) && (err_q == ERR_OK) && !we_q && (rd_q != 5'd0);
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus randomized LW/SW traffic against a spec-level model.
module tb_lsu_ctrl;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_instr = '0;
  logic [31:0] req_rs1_val = '0;
  logic [31:0] req_rs2_val = '0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        cmpl_valid;
  logic [1:0]  cmpl_err;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  int checks = 0;
  int failures = 0;

  // observations of the latest transaction
  bit          o_req_seen, o_unstable, o_wbv_at, o_timeout;
  logic [31:0] o_addr, o_wdata, o_wbdata;
  logic        o_we;
  logic [3:0]  o_be;
  logic [1:0]  o_err;
  logic [4:0]  o_wbrd;
  int          o_hs, o_cmpl, o_ncmpl, o_nwb, o_errleak, o_busy_gap, o_ready_cyc;

  // write-back registers as the model expects them to hold
  logic [4:0]  exp_wbrd = '0;
  logic [31:0] exp_wbdata = '0;

  lsu_ctrl #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_instr(req_instr),
    .req_rs1_val(req_rs1_val), .req_rs2_val(req_rs2_val),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_be(mem_be),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .cmpl_valid(cmpl_valid), .cmpl_err(cmpl_err),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction

  // Reference: decode, effective address and error code straight from the ISA rules.
  function automatic void ref_model(input logic [31:0] instr, input logic [31:0] rs1,
                                    output logic [1:0] err, output logic [31:0] addr, output bit ld);
    int unsigned opc, f3;
    int off;
    opc = instr & 32'h7f;
    f3  = (instr >> 12) & 32'h7;
    ld  = (opc == 3);
    if (ld) off = int'((instr >> 20) & 32'hfff);
    else    off = int'(((instr >> 25) << 5) | ((instr >> 7) & 32'h1f));
    if (off >= 2048) off = off - 4096;
    addr = rs1 + off;
    if (!(opc == 3 || opc == 35) || f3 != 2) err = 2;
    else if (addr % 4 != 0)                  err = 1;
    else                                      err = 0;
  endfunction

  // Offers one instruction (cycle 0) and plays the memory side; rsp_wait<0 means never respond.
  task automatic do_txn(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                        input int rdy_wait, input int rsp_wait, input logic [31:0] rdata,
                        input bit spur, input int budget);
    int  issue_n;
    bit  done;
    o_req_seen = 0; o_unstable = 0; o_wbv_at = 0; o_timeout = 0;
    o_addr = '0; o_wdata = '0; o_we = 0; o_be = '0; o_err = '0; o_wbrd = '0; o_wbdata = '0;
    o_hs = -1; o_cmpl = -1; o_ncmpl = 0; o_nwb = 0; o_errleak = 0; o_busy_gap = 0; o_ready_cyc = -1;
    for (int w = 0; w < 20 && !req_ready; w++) step();
    req_valid = 1'b1; req_instr = instr; req_rs1_val = rs1; req_rs2_val = rs2;
    step();
    req_valid = 1'b0; req_instr = $urandom; req_rs1_val = $urandom; req_rs2_val = $urandom;
    issue_n = 0; done = 0;
    for (int cyc = 1; cyc <= budget && !done; cyc++) begin
      mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = $urandom;
      if (cmpl_valid) begin
        o_ncmpl++;
        if (o_cmpl < 0) begin
          o_cmpl = cyc; o_err = cmpl_err; o_wbv_at = wb_valid; o_wbrd = wb_rd; o_wbdata = wb_data;
        end
      end
      if (wb_valid) o_nwb++;
      if (!cmpl_valid && cmpl_err != 2'b00) o_errleak++;
      if (o_cmpl < 0 && !busy) o_busy_gap++;
      if (o_cmpl >= 0 && !cmpl_valid && req_ready) begin
        o_ready_cyc = cyc; done = 1;
      end
      if (mem_req_valid) begin
        if (!o_req_seen) begin
          o_addr = mem_addr; o_wdata = mem_wdata; o_we = mem_we; o_be = mem_be;
        end else if (mem_addr !== o_addr || mem_wdata !== o_wdata || mem_we !== o_we) begin
          o_unstable = 1;
        end
        o_req_seen = 1;
        if (spur) mem_rsp_valid = 1'b1;
        if (issue_n >= rdy_wait) begin
          mem_req_ready = 1'b1; o_hs = cyc;
        end
        issue_n++;
      end else if (o_hs >= 0 && rsp_wait >= 0 && cyc == o_hs + rsp_wait) begin
        mem_rsp_valid = 1'b1; mem_rdata = rdata;
      end
      if (!done) step();
    end
    if (!done) o_timeout = 1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    checks++;
    if ({req_ready, busy, mem_req_valid, mem_we, cmpl_valid, cmpl_err, wb_valid} !== 8'b1000_0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected %b",
               {req_ready, busy, mem_req_valid, mem_we, cmpl_valid, cmpl_err, wb_valid}, 8'b1000_0000);
    end
    checks++;
    if ({mem_addr, mem_wdata, wb_rd, wb_data} !== '0) begin
      failures++;
      $display("FAIL reset_data: addr=%h wdata=%h wb_rd=%0d wb_data=%h expected all zero",
               mem_addr, mem_wdata, wb_rd, wb_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lw();
    do_txn(enc_i(12'h010, 5'd2, 3'b010, 5'd5, 7'b0000011), 32'h0000_1000, 32'h1234_5678,
           0, 1, 32'hDEAD_BEEF, 0, 50);
    exp_wbrd = 5'd5; exp_wbdata = 32'hDEAD_BEEF;
    checks++;
    if (!o_req_seen || o_addr !== 32'h1010 || o_we !== 1'b0 || o_be !== 4'hF) begin
      failures++;
      $display("FAIL lw_req: seen=%0d addr=%h we=%b be=%h expected 1 00001010 0 f",
               o_req_seen, o_addr, o_we, o_be);
    end
    checks++;
    if (o_cmpl != 3 || o_err !== 2'b00 || o_wbv_at !== 1'b1 || o_wbrd !== 5'd5 || o_wbdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL lw_cmpl: cyc=%0d err=%b wbv=%b rd=%0d data=%h expected 3 00 1 5 deadbeef",
               o_cmpl, o_err, o_wbv_at, o_wbrd, o_wbdata);
    end
    checks++;
    if (o_ready_cyc != 4 || o_ncmpl != 1 || o_errleak != 0) begin
      failures++;
      $display("FAIL lw_after: ready_cyc=%0d pulses=%0d err_leak=%0d expected 4 1 0",
               o_ready_cyc, o_ncmpl, o_errleak);
    end
  endtask

  task automatic test_sw_neg();
    do_txn(enc_s(12'hFFC, 5'd9, 5'd3, 3'b010), 32'h0000_2000, 32'hCAFE_F00D, 0, 2, 32'h5555_5555, 0, 50);
    checks++;
    if (!o_req_seen || o_addr !== 32'h1FFC || o_we !== 1'b1 || o_wdata !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL sw_req: seen=%0d addr=%h we=%b wdata=%h expected 1 00001ffc 1 cafef00d",
               o_req_seen, o_addr, o_we, o_wdata);
    end
    checks++;
    if (o_cmpl != 4 || o_err !== 2'b00 || o_nwb != 0 || o_wbrd !== exp_wbrd || o_wbdata !== exp_wbdata) begin
      failures++;
      $display("FAIL sw_cmpl: cyc=%0d err=%b wb_pulses=%0d rd=%0d data=%h expected 4 00 0 %0d %h",
               o_cmpl, o_err, o_nwb, o_wbrd, o_wbdata, exp_wbrd, exp_wbdata);
    end
  endtask

  task automatic test_errors();
    logic [31:0] instr [3];
    logic [31:0] base [3];
    logic [1:0]  want [3];
    instr[0] = enc_i(12'h000, 5'd1, 3'b010, 5'd4, 7'b0000011); base[0] = 32'h1002; want[0] = 2'b01;
    instr[1] = enc_i(12'h000, 5'd1, 3'b000, 5'd4, 7'b0000011); base[1] = 32'h1000; want[1] = 2'b10;
    instr[2] = enc_i(12'h001, 5'd1, 3'b010, 5'd4, 7'b0110011); base[2] = 32'h1000; want[2] = 2'b10;
    for (int i = 0; i < 3; i++) begin
      do_txn(instr[i], base[i], $urandom, 0, 1, $urandom, 0, 20);
      checks++;
      if (o_req_seen || o_cmpl != 1 || o_err !== want[i] || o_nwb != 0 || o_ready_cyc != 2) begin
        failures++;
        $display("FAIL err_case%0d: req=%0d cyc=%0d err=%b wb=%0d ready=%0d expected 0 1 %b 0 2",
                 i, o_req_seen, o_cmpl, o_err, o_nwb, o_ready_cyc, want[i]);
      end
    end
  endtask

  task automatic test_wrap_and_x0();
    do_txn(enc_i(12'h020, 5'd6, 3'b010, 5'd0, 7'b0000011), 32'hFFFF_FFF0, $urandom, 1, 1, 32'hA5A5_0001, 0, 30);
    checks++;
    if (!o_req_seen || o_addr !== 32'h0000_0010 || o_err !== 2'b00 || o_nwb != 0 ||
        o_wbrd !== exp_wbrd || o_wbdata !== exp_wbdata) begin
      failures++;
      $display("FAIL wrap_x0: req=%0d addr=%h err=%b wb=%0d rd=%0d data=%h expected 1 00000010 00 0 %0d %h",
               o_req_seen, o_addr, o_err, o_nwb, o_wbrd, o_wbdata, exp_wbrd, exp_wbdata);
    end
  endtask

  task automatic test_backpressure();
    do_txn(enc_i(12'h008, 5'd2, 3'b010, 5'd12, 7'b0000011), 32'h0000_4000, 32'h0BAD_F00D,
           3, 2, 32'h1357_9BDF, 1, 40);
    exp_wbrd = 5'd12; exp_wbdata = 32'h1357_9BDF;
    checks++;
    if (o_unstable || o_hs != 4 || o_addr !== 32'h4008 || o_wdata !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL bp_hold: unstable=%0d hs=%0d addr=%h wdata=%h expected 0 4 00004008 0badf00d",
               o_unstable, o_hs, o_addr, o_wdata);
    end
    checks++;
    if (o_cmpl != 7 || o_err !== 2'b00 || o_ncmpl != 1 || o_wbdata !== exp_wbdata || o_wbrd !== exp_wbrd) begin
      failures++;
      $display("FAIL bp_cmpl: cyc=%0d err=%b pulses=%0d rd=%0d data=%h expected 7 00 1 %0d %h",
               o_cmpl, o_err, o_ncmpl, o_wbrd, o_wbdata, exp_wbrd, exp_wbdata);
    end
  endtask

`ifdef LSU_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    int bad;
    do_txn(enc_i(12'h004, 5'd2, 3'b010, 5'd9, 7'b0000011), 32'h0000_3000, $urandom, 0, -1, $urandom, 0, 60);
    checks++;
    if (o_cmpl != 1 + TO + 1 || o_err !== 2'b11 || o_nwb != 0 || o_busy_gap != 0) begin
      failures++;
      $display("FAIL to_fire: cyc=%0d err=%b wb=%0d gap=%0d expected %0d 11 0 0",
               o_cmpl, o_err, o_nwb, o_busy_gap, 1 + TO + 1);
    end
    step();
    mem_rsp_valid = 1'b1; mem_rdata = $urandom;
    step();
    mem_rsp_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (cmpl_valid || wb_valid || !req_ready || busy) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL to_late_rsp: bad_cycles=%0d expected 0", bad);
    end
    do_txn(enc_i(12'h004, 5'd2, 3'b010, 5'd10, 7'b0000011), 32'h0000_3000, $urandom, 0, TO, 32'h7777_0001, 0, 60);
    exp_wbrd = 5'd10; exp_wbdata = 32'h7777_0001;
    checks++;
    if (o_cmpl != 1 + TO + 1 || o_err !== 2'b00 || o_wbv_at !== 1'b1 || o_wbdata !== exp_wbdata) begin
      failures++;
      $display("FAIL to_last_cycle: cyc=%0d err=%b wbv=%b data=%h expected %0d 00 1 %h",
               o_cmpl, o_err, o_wbv_at, o_wbdata, 1 + TO + 1, exp_wbdata);
    end
  endtask
`else
  task automatic test_no_timeout();
    do_txn(enc_s(12'h010, 5'd7, 5'd2, 3'b010), 32'h0000_3000, $urandom, 0, 40, $urandom, 0, 80);
    checks++;
    if (o_cmpl != 42 || o_err !== 2'b00 || o_busy_gap != 0 || o_ncmpl != 1) begin
      failures++;
      $display("FAIL hold_wait: cyc=%0d err=%b gap=%0d pulses=%0d expected 42 00 0 1",
               o_cmpl, o_err, o_busy_gap, o_ncmpl);
    end
  endtask
`endif

  task automatic test_reset_in_wait();
    int bad;
    req_valid = 1'b1; req_instr = enc_i(12'h000, 5'd2, 3'b010, 5'd7, 7'b0000011);
    req_rs1_val = 32'h0000_5000; req_rs2_val = $urandom;
    step();
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    checks++;
    if (!busy || mem_req_valid || cmpl_valid) begin
      failures++;
      $display("FAIL rst_setup: busy=%b req=%b cmpl=%b expected 1 0 0", busy, mem_req_valid, cmpl_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, busy, mem_req_valid, cmpl_valid, wb_valid} !== 5'b10000 ||
        {mem_addr, mem_wdata, mem_we, wb_rd, wb_data} !== '0) begin
      failures++;
      $display("FAIL rst_async: rdy=%b busy=%b cmpl=%b addr=%h wb_rd=%0d wb_data=%h expected 1 0 0 0 0 0",
               req_ready, busy, cmpl_valid, mem_addr, wb_rd, wb_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_wbrd = '0; exp_wbdata = '0;
    mem_rsp_valid = 1'b1; mem_rdata = $urandom;
    step();
    mem_rsp_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (cmpl_valid || wb_valid || busy) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_stray: bad_cycles=%0d expected 0", bad);
    end
    do_txn(enc_i(12'h7FC, 5'd2, 3'b010, 5'd31, 7'b0000011), 32'h0000_0004, $urandom, 0, 1, 32'h0F0F_1234, 0, 30);
    checks++;
    if (o_addr !== 32'h0000_0800 || o_cmpl != 3 || o_wbv_at !== 1'b1 || o_wbrd !== 5'd31 || o_wbdata !== 32'h0F0F_1234) begin
      failures++;
      $display("FAIL rst_recover: addr=%h cyc=%0d wbv=%b rd=%0d data=%h expected 00000800 3 1 31 0f0f1234",
               o_addr, o_cmpl, o_wbv_at, o_wbrd, o_wbdata);
    end
    exp_wbrd = 5'd31; exp_wbdata = 32'h0F0F_1234;
  endtask

  task automatic test_random();
    logic [31:0] instr, rs1, rs2, rdata, e_addr;
    logic [11:0] imm;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [1:0]  e_err;
    bit          e_ld, e_wb, spur;
    int          kind, rdy_w, rsp_w, e_cmpl;
    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 9);
      rs1 = $urandom; rs2 = $urandom; rdata = $urandom; imm = 12'($urandom);
      rd = 5'($urandom_range(0, 31)); f3 = 3'b010;
      if (kind <= 6) begin
        rs1 = rs1 & 32'hFFFF_FFFC; imm = imm & 12'hFFC;
      end
      if (kind == 8) begin
        f3 = 3'($urandom_range(0, 7));
        if (f3 == 3'b010) f3 = 3'b011;
      end
      if (kind <= 3 || kind == 8) instr = enc_i(imm, 5'($urandom), f3, rd, 7'b0000011);
      else if (kind <= 6)         instr = enc_s(imm, 5'($urandom), 5'($urandom), f3);
      else if (kind == 7)         instr = (t % 2 == 0) ? enc_i(imm, 5'($urandom), f3, rd, 7'b0000011)
                                                       : enc_s(imm, 5'($urandom), 5'($urandom), f3);
      else                        instr = $urandom;
      rdy_w = $urandom_range(0, 3); rsp_w = $urandom_range(1, 4); spur = ($urandom_range(0, 1) == 1);
      ref_model(instr, rs1, e_err, e_addr, e_ld);
      e_wb   = (e_err == 2'b00) && e_ld && (instr[11:7] != 5'd0);
      e_cmpl = (e_err != 2'b00) ? 1 : 1 + rdy_w + rsp_w + 1;
      if (e_wb) begin
        exp_wbrd = instr[11:7]; exp_wbdata = rdata;
      end
      do_txn(instr, rs1, rs2, rdy_w, rsp_w, rdata, spur, 40);
      checks++;
      if (o_timeout || o_cmpl != e_cmpl || o_err !== e_err || o_ncmpl != 1 || o_ready_cyc != e_cmpl + 1) begin
        failures++;
        $display("FAIL rnd%0d_cmpl: instr=%h cyc=%0d err=%b pulses=%0d ready=%0d expected %0d %b 1 %0d",
                 t, instr, o_cmpl, o_err, o_ncmpl, o_ready_cyc, e_cmpl, e_err, e_cmpl + 1);
      end
      checks++;
      if (o_req_seen !== (e_err == 2'b00) ||
          (e_err == 2'b00 && (o_addr !== e_addr || o_we !== !e_ld || o_wdata !== rs2 || o_unstable))) begin
        failures++;
        $display("FAIL rnd%0d_req: seen=%0d addr=%h we=%b wdata=%h unstable=%0d expected %0d %h %b %h 0",
                 t, o_req_seen, o_addr, o_we, o_wdata, o_unstable, e_err == 2'b00, e_addr, !e_ld, rs2);
      end
      checks++;
      if (o_wbv_at !== e_wb || o_nwb != int'(e_wb) || o_wbrd !== exp_wbrd || o_wbdata !== exp_wbdata ||
          o_errleak != 0 || o_busy_gap != 0) begin
        failures++;
        $display("FAIL rnd%0d_wb: wbv=%b n=%0d rd=%0d data=%h leak=%0d gap=%0d expected %b %0d %0d %h 0 0",
                 t, o_wbv_at, o_nwb, o_wbrd, o_wbdata, o_errleak, o_busy_gap, e_wb, int'(e_wb), exp_wbrd, exp_wbdata);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_neg();
    test_errors();
    test_wrap_and_x0();
    test_backpressure();
`ifdef LSU_CTRL_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_in_wait();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
